// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

    typedef enum logic {
        StFetch = 1'b0,
        StIssue = 1'b1
    } state_e;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_JMP = 2'd2;
    localparam logic [1:0] SEL_INT = 2'd3;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_INT_VEC   = 32'h0000_0080;
    localparam int unsigned DEF_STEP      = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC candidate generation, select priority and check of the external
// mux result against the selected candidate.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INT_VEC = WIDTH'(DEF_INT_VEC),
    parameter int unsigned      STEP    = DEF_STEP
) (
    input  logic             active_i,
    input  logic             int_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             zero_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [WIDTH-1:0] jtarget_i,
    input  logic [WIDTH-1:0] mux_z_i,
    output logic [WIDTH-1:0] a0_o,
    output logic [WIDTH-1:0] a1_o,
    output logic [WIDTH-1:0] a2_o,
    output logic [WIDTH-1:0] a3_o,
    output logic [1:0]       sel_o,
    output logic             mismatch_o
);

    logic [WIDTH-1:0] expected;

    always_comb begin
        a0_o = pc_i + WIDTH'(STEP);
        a1_o = pc_i + WIDTH'(STEP) + imm_i;
        a2_o = jtarget_i;
        a3_o = INT_VEC;

        // Select is only meaningful while an instruction is issuing.
        sel_o = SEL_SEQ;
        if (active_i) begin
            if (int_i) begin
                sel_o = SEL_INT;
            end else if (jump_i) begin
                sel_o = SEL_JMP;
            end else if (branch_i && zero_i) begin
                sel_o = SEL_BR;
            end
        end

        expected = a0_o;
        unique case (sel_o)
            SEL_SEQ: expected = a0_o;
            SEL_BR:  expected = a1_o;
            SEL_JMP: expected = a2_o;
            SEL_INT: expected = a3_o;
        endcase

        // Case inequality so an X/Z on the mux output is flagged too.
        mismatch_o = (mux_z_i !== expected);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer: fetches over req/ack, drives next-PC candidates to
// an external 4:1 mux and registers its result as the new PC.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] INT_VEC   = WIDTH'(DEF_INT_VEC),
    parameter int unsigned      STEP      = DEF_STEP
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      ins_o,
    output logic             ins_valid_o,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             zero_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [WIDTH-1:0] jtarget_i,
    input  logic             int_req_i,
    output logic [WIDTH-1:0] mux_a0_o,
    output logic [WIDTH-1:0] mux_a1_o,
    output logic [WIDTH-1:0] mux_a2_o,
    output logic [WIDTH-1:0] mux_a3_o,
    output logic [1:0]       mux_c_o,
    input  logic [WIDTH-1:0] mux_z_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             mux_err_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ins_q, ins_d;
    logic             int_pend_q, int_pend_d;
    logic             err_q, err_d;
    logic             req_en_q;
    logic             issue, fetch_done, update, mismatch;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // req_en_q keeps imem_req low on the edge that applies reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pc_q       <= RESET_VEC;
            ins_q      <= '0;
            int_pend_q <= 1'b0;
            err_q      <= 1'b0;
            req_en_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ins_q      <= ins_d;
            int_pend_q <= int_pend_d;
            err_q      <= err_d;
            req_en_q   <= 1'b1;
        end
    end

    assign issue      = (state_q == StIssue);
    assign fetch_done = (state_q == StFetch) && req_en_q && imem_ack_i;
    assign update     = issue && !stall_i;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: if (fetch_done) state_d = StIssue;
            StIssue: if (!stall_i)   state_d = StFetch;
        endcase
    end

    // Outputs.
    always_comb begin
        imem_req_o  = (state_q == StFetch) && req_en_q;
        ins_valid_o = issue;
        imem_addr_o = pc_q;
        pc_o        = pc_q;
        ins_o       = ins_q;
        mux_err_o   = err_q;
    end

    pc_next_sel #(
        .WIDTH   (WIDTH),
        .INT_VEC (INT_VEC),
        .STEP    (STEP)
    ) u_next_sel (
        .active_i   (issue),
        .int_i      (int_pend_q | int_req_i),
        .jump_i     (jump_i),
        .branch_i   (branch_i),
        .zero_i     (zero_i),
        .pc_i       (pc_q),
        .imm_i      (imm_i),
        .jtarget_i  (jtarget_i),
        .mux_z_i    (mux_z_i),
        .a0_o       (mux_a0_o),
        .a1_o       (mux_a1_o),
        .a2_o       (mux_a2_o),
        .a3_o       (mux_a3_o),
        .sel_o      (mux_c_o),
        .mismatch_o (mismatch)
    );

    // Datapath next values.
    always_comb begin
        pc_d  = update ? mux_z_i : pc_q;
        ins_d = fetch_done ? imem_rdata_i : ins_q;
        err_d = err_q | (update & mismatch);
        // A request arriving in the take cycle is consumed by that take.
        if (update && mux_c_o == SEL_INT) begin
            int_pend_d = 1'b0;
        end else begin
            int_pend_d = int_pend_q | int_req_i;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table-driven instruction vectors, a PC scoreboard
// and hand-written stall / stray-ack / reset sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        ins_valid;
    logic        stall, branch, zero, jump, int_req;
    logic [31:0] imm, jtarget;
    logic [31:0] mux_a0, mux_a1, mux_a2, mux_a3, mux_z;
    logic [1:0]  mux_c;
    logic [31:0] pc;
    logic        mux_err;

    logic        force_en;
    logic [31:0] force_val;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];
    logic        upd_q = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .ins_o        (ins),
        .ins_valid_o  (ins_valid),
        .stall_i      (stall),
        .branch_i     (branch),
        .zero_i       (zero),
        .jump_i       (jump),
        .imm_i        (imm),
        .jtarget_i    (jtarget),
        .int_req_i    (int_req),
        .mux_a0_o     (mux_a0),
        .mux_a1_o     (mux_a1),
        .mux_a2_o     (mux_a2),
        .mux_a3_o     (mux_a3),
        .mux_c_o      (mux_c),
        .mux_z_i      (mux_z),
        .pc_o         (pc),
        .mux_err_o    (mux_err)
    );

    // Behavioural yMux4to1, with an override to inject a bad mux result.
    always_comb begin
        case (mux_c)
            2'd0:    mux_z = mux_a0;
            2'd1:    mux_z = mux_a1;
            2'd2:    mux_z = mux_a2;
            default: mux_z = mux_a3;
        endcase
        if (force_en) mux_z = force_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: an expected PC is queued before each update edge.
    always @(posedge clk) upd_q <= reset_n && ins_valid && !stall;

    always @(negedge clk) begin
        if (upd_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pc_update: got %h expected <nothing queued>", pc);
            end else begin
                chk("pc_update", pc, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        br, zr, jmp, irq;
        logic [31:0] imm, jt;
        int          ack_dly, stalls;
        logic        fz;
        logic [31:0] zval;
        logic [1:0]  exp_c;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic clear_ctrl();
        branch = 1'b0; zero = 1'b0; jump = 1'b0; imm = '0; jtarget = '0;
        stall = 1'b0; force_en = 1'b0; force_val = '0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) chk("imem_req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        wait_req();
        chk("imem_addr", imem_addr, model_pc);
        if (v.irq) begin
            int_req = 1'b1;
            @(negedge clk);
            int_req = 1'b0;
        end
        repeat (v.ack_dly) @(negedge clk);
        chk("imem_req_held", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = '0;
        branch = v.br; zero = v.zr; jump = v.jmp; imm = v.imm; jtarget = v.jt;
        stall = (v.stalls > 0);
        force_en = v.fz; force_val = v.zval;
        #1;
        chk("ins", ins, v.rdata);
        chk("ins_valid", 32'(ins_valid), 32'd1);
        chk("issue_no_req", 32'(imem_req), 32'd0);
        chk("mux_c", 32'(mux_c), 32'(v.exp_c));
        chk("mux_a0", mux_a0, model_pc + 32'd4);
        chk("mux_a1", mux_a1, model_pc + 32'd4 + v.imm);
        chk("mux_a2", mux_a2, v.jt);
        chk("mux_a3", mux_a3, 32'h80);
        for (int s = 0; s < v.stalls; s++) begin
            @(negedge clk);
            chk("stall_pc", pc, model_pc);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_valid", 32'(ins_valid), 32'd1);
        end
        stall = 1'b0;
        exp_q.push_back(v.exp_pc);
        @(negedge clk);
        clear_ctrl();
        #1;
        chk("mux_err", 32'(mux_err), 32'(v.exp_err));
        chk("back_to_fetch", 32'(ins_valid), 32'd0);
        model_pc = v.exp_pc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        //           rdata         br zr jm ir imm           jt            dly st fz zval  c  exp_pc        err
        vecs[0]  = '{32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        32'h0,        2,  0, 0, 32'h0, 0, 32'h4,        0};
        vecs[1]  = '{32'h00000001, 0, 0, 1, 0, 32'h0,        32'h10,       0,  0, 0, 32'h0, 2, 32'h10,       0};
        vecs[2]  = '{32'h00000002, 1, 1, 0, 0, 32'h20,       32'h0,        0,  0, 0, 32'h0, 1, 32'h34,       0};
        vecs[3]  = '{32'h00000003, 0, 0, 1, 0, 32'h0,        32'h10,       1,  0, 0, 32'h0, 2, 32'h10,       0};
        vecs[4]  = '{32'h00000004, 1, 0, 0, 0, 32'h20,       32'h0,        0,  0, 0, 32'h0, 0, 32'h14,       0};
        vecs[5]  = '{32'h00000005, 1, 1, 1, 0, 32'h20,       32'h1000,     0,  0, 0, 32'h0, 2, 32'h1000,     0};
        vecs[6]  = '{32'h00000006, 0, 0, 1, 1, 32'h0,        32'h2000,     1,  0, 0, 32'h0, 3, 32'h80,       0};
        vecs[7]  = '{32'h00000007, 0, 0, 0, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0, 0, 32'h84,       0};
        vecs[8]  = '{32'h00000008, 0, 0, 0, 0, 32'h0,        32'h0,        0,  3, 0, 32'h0, 0, 32'h88,       0};
        vecs[9]  = '{32'h00000009, 0, 0, 1, 0, 32'h0,        32'hFFFFFFFC, 0,  0, 0, 32'h0, 2, 32'hFFFFFFFC, 0};
        vecs[10] = '{32'h0000000A, 0, 0, 0, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0, 0, 32'h0,        0};
        vecs[11] = '{32'h0000000B, 1, 1, 0, 0, 32'hFFFFFFF8, 32'h0,        0,  0, 0, 32'h0, 1, 32'hFFFFFFFC, 0};
        vecs[12] = '{32'h0000000C, 0, 0, 1, 0, 32'h0,        32'h4,        0,  0, 0, 32'h0, 2, 32'h4,        0};
        vecs[13] = '{32'h0000000D, 0, 0, 0, 0, 32'h0,        32'h0,        0,  0, 1, 32'h0, 0, 32'h0,        1};
        vecs[14] = '{32'h0000000E, 0, 0, 0, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0, 0, 32'h4,        1};

        reset_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        int_req = 1'b0;
        clear_ctrl();
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_mux_c", 32'(mux_c), 32'd0);
        chk("rst_err", 32'(mux_err), 32'd0);
        reset_n = 1'b1;
        model_pc = 32'h0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Stray ack in ISSUE is ignored; int_req sets pending while stalled;
        // reset mid-stall abandons the instruction and clears the error flag.
        wait_req();
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        imem_ack = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'h11111111;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stray_ack_ins", ins, 32'hCAFEF00D);
        chk("stray_ack_valid", 32'(ins_valid), 32'd1);
        chk("stray_ack_pc", pc, 32'h4);
        int_req = 1'b1;
        @(negedge clk);
        int_req = 1'b0;
        #1;
        chk("stall_int_pend", 32'(mux_c), 32'd3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", 32'(ins_valid), 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_ins", ins, 32'h0);
        chk("midrst_err", 32'(mux_err), 32'd0);
        reset_n = 1'b1;
        clear_ctrl();
        model_pc = 32'h0;
        run_vec(vecs[0]);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
